inv_shift_row_byte_sub: RTL and testbench

- AES-decrypt round stage that performs InvShiftRows plus InvSubBytes in place on the 16-word state memory `statemt`.
- Sits between the round-key XOR stage and the inverse MixColumns stage, on the same dual-port `statemt` RAM, under ap_ctrl_hs-style start/done control.
- The inverse S-box is an external 256-entry ROM with a 1-cycle read latency.
- Carries an 8-bit locking key input, in the same way as the other locked stages.

---
 rtl/inv_shift_row_byte_sub_if.sv | 50 +++++
 rtl/inv_shift_row_byte_sub.sv | 153 +++++++++++++++
 tb/tb_inv_shift_row_byte_sub.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_shift_row_byte_sub_if.sv
// Control handshake plus statemt RAM and inverse S-box ROM buses
// for the AES InvShiftRows/InvSubBytes stage.
interface inv_shift_row_byte_sub_if;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic [4:0]  statemt_address0;
   logic [4:0]  statemt_address1;
   logic        statemt_ce0;
   logic        statemt_ce1;
   logic        statemt_we0;
   logic        statemt_we1;
   logic [31:0] statemt_d0;
   logic [31:0] statemt_d1;
   logic [31:0] statemt_q0;
   logic [31:0] statemt_q1;
   logic [7:0]  invSbox_address0;
   logic [7:0]  invSbox_address1;
   logic        invSbox_ce0;
   logic        invSbox_ce1;
   logic [7:0]  invSbox_q0;
   logic [7:0]  invSbox_q1;

   modport master (
      input  ap_start,
      output ap_done, ap_idle, ap_ready,
      output statemt_address0, statemt_address1,
      output statemt_ce0, statemt_ce1,
      output statemt_we0, statemt_we1,
      output statemt_d0, statemt_d1,
      input  statemt_q0, statemt_q1,
      output invSbox_address0, invSbox_address1,
      output invSbox_ce0, invSbox_ce1,
      input  invSbox_q0, invSbox_q1
   );

   modport slave (
      output ap_start,
      input  ap_done, ap_idle, ap_ready,
      input  statemt_address0, statemt_address1,
      input  statemt_ce0, statemt_ce1,
      input  statemt_we0, statemt_we1,
      input  statemt_d0, statemt_d1,
      output statemt_q0, statemt_q1,
      input  invSbox_address0, invSbox_address1,
      input  invSbox_ce0, invSbox_ce1,
      output invSbox_q0, invSbox_q1
   );
endinterface

// File: rtl/inv_shift_row_byte_sub.sv
// AES-decrypt stage: in-place InvShiftRows + InvSubBytes on the
// 16-word statemt RAM, reading through an external inverse S-box ROM.
module inv_shift_row_byte_sub #(
   parameter int         SBOX_AW   = 8,
   parameter logic [1:0] KEY_OK    = 2'b10,
   parameter logic [7:0] SPUR_MASK = 8'h1B
) (
   input logic                   ap_clk,
   input logic                   ap_rst_n,
   input logic [7:0]             working_key,
   inv_shift_row_byte_sub_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD, LCAP, LKP, WB, DONE
   } state_t;

   state_t               state;
   logic [2:0]           k;
   logic [2:0]           p;
   logic [2:0]           p_nx;
   logic [SBOX_AW-1:0]   sbuf [16];
   logic [4:0]           sa0, sa1;
   logic                 sce0, sce1;
   logic                 swe0, swe1;
   logic [SBOX_AW-1:0]   ra0, ra1;
   logic                 rce0, rce1;
   logic                 done_q;
   logic [7:0]           mask;
   logic                 unused_bits;

   // Source byte of output slot i: same row, column shifted by row.
   function automatic logic [3:0] src(input logic [3:0] i);
      return {i[3:2] - i[1:0], i[1:0]};
   endfunction

   assign p_nx = (state == WB) ? p + 3'd1 : 3'd0;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state  <= IDLE;
         k      <= '0;
         p      <= '0;
         sa0    <= '0;
         sa1    <= '0;
         sce0   <= 1'b0;
         sce1   <= 1'b0;
         swe0   <= 1'b0;
         swe1   <= 1'b0;
         ra0    <= '0;
         ra1    <= '0;
         rce0   <= 1'b0;
         rce1   <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < 16; i++) sbuf[i] <= '0;
      end else begin
         sce0   <= 1'b0;
         sce1   <= 1'b0;
         swe0   <= 1'b0;
         swe1   <= 1'b0;
         rce0   <= 1'b0;
         rce1   <= 1'b0;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.ap_start) begin
                  k     <= '0;
                  state <= LOAD;
                  sce0  <= 1'b1;
                  sce1  <= 1'b1;
                  sa0   <= 5'd0;
                  sa1   <= 5'd1;
               end
            end
            LOAD: begin
               if (k != 3'd0) begin
                  sbuf[{k - 3'd1, 1'b0}] <= bus.statemt_q0[7:0];
                  sbuf[{k - 3'd1, 1'b1}] <= bus.statemt_q1[7:0];
               end
               if (k == 3'd7) begin
                  state <= LCAP;
               end else begin
                  k    <= k + 3'd1;
                  sce0 <= 1'b1;
                  sce1 <= 1'b1;
                  sa0  <= {1'b0, k + 3'd1, 1'b0};
                  sa1  <= {1'b0, k + 3'd1, 1'b1};
               end
            end
            LCAP: begin
               sbuf[14] <= bus.statemt_q0[7:0];
               sbuf[15] <= bus.statemt_q1[7:0];
               p        <= '0;
               state    <= LKP;
               rce0     <= 1'b1;
               rce1     <= 1'b1;
               ra0      <= sbuf[src({p_nx, 1'b0})];
               ra1      <= sbuf[src({p_nx, 1'b1})];
            end
            LKP: begin
               state <= WB;
               sce0  <= 1'b1;
               sce1  <= 1'b1;
               swe0  <= 1'b1;
               swe1  <= 1'b1;
               sa0   <= {1'b0, p, 1'b0};
               sa1   <= {1'b0, p, 1'b1};
            end
            WB: begin
               if (p == 3'd7) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  p     <= p_nx;
                  state <= LKP;
                  rce0  <= 1'b1;
                  rce1  <= 1'b1;
                  ra0   <= sbuf[src({p_nx, 1'b0})];
                  ra1   <= sbuf[src({p_nx, 1'b1})];
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ROM data only arrives in WB, so write data is formed there.
   assign mask = (working_key[5:4] == KEY_OK) ? 8'h00 : SPUR_MASK;

   assign bus.statemt_d0 = (state == WB) ?
      {24'b0, bus.invSbox_q0 ^ mask} : 32'b0;
   assign bus.statemt_d1 = (state == WB) ?
      {24'b0, bus.invSbox_q1 ^ mask} : 32'b0;

   assign bus.statemt_address0 = sa0;
   assign bus.statemt_address1 = sa1;
   assign bus.statemt_ce0      = sce0;
   assign bus.statemt_ce1      = sce1;
   assign bus.statemt_we0      = swe0;
   assign bus.statemt_we1      = swe1;
   assign bus.invSbox_address0 = ra0;
   assign bus.invSbox_address1 = ra1;
   assign bus.invSbox_ce0      = rce0;
   assign bus.invSbox_ce1      = rce1;
   assign bus.ap_done          = done_q;
   assign bus.ap_ready         = done_q;
   assign bus.ap_idle          = (state == IDLE) && !bus.ap_start;

   assign unused_bits = ^{working_key[7:6], working_key[3:0],
                          bus.statemt_q0[31:8], bus.statemt_q1[31:8]};

endmodule

// File: tb/tb_inv_shift_row_byte_sub.sv
// Bench for inv_shift_row_byte_sub: vector table, write scoreboard,
// mid-run reset and back-to-back start sequences.
module tb_inv_shift_row_byte_sub;

   typedef logic [15:0][31:0] words_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      words_t     in;
      logic [7:0] key;
      words_t     exp;
   } vec_t;

   localparam logic [7:0] INV [256] = '{
      'h52,'h09,'h6a,'hd5,'h30,'h36,'ha5,'h38,'hbf,'h40,'ha3,'h9e,'h81,'hf3,'hd7,'hfb,
      'h7c,'he3,'h39,'h82,'h9b,'h2f,'hff,'h87,'h34,'h8e,'h43,'h44,'hc4,'hde,'he9,'hcb,
      'h54,'h7b,'h94,'h32,'ha6,'hc2,'h23,'h3d,'hee,'h4c,'h95,'h0b,'h42,'hfa,'hc3,'h4e,
      'h08,'h2e,'ha1,'h66,'h28,'hd9,'h24,'hb2,'h76,'h5b,'ha2,'h49,'h6d,'h8b,'hd1,'h25,
      'h72,'hf8,'hf6,'h64,'h86,'h68,'h98,'h16,'hd4,'ha4,'h5c,'hcc,'h5d,'h65,'hb6,'h92,
      'h6c,'h70,'h48,'h50,'hfd,'hed,'hb9,'hda,'h5e,'h15,'h46,'h57,'ha7,'h8d,'h9d,'h84,
      'h90,'hd8,'hab,'h00,'h8c,'hbc,'hd3,'h0a,'hf7,'he4,'h58,'h05,'hb8,'hb3,'h45,'h06,
      'hd0,'h2c,'h1e,'h8f,'hca,'h3f,'h0f,'h02,'hc1,'haf,'hbd,'h03,'h01,'h13,'h8a,'h6b,
      'h3a,'h91,'h11,'h41,'h4f,'h67,'hdc,'hea,'h97,'hf2,'hcf,'hce,'hf0,'hb4,'he6,'h73,
      'h96,'hac,'h74,'h22,'he7,'had,'h35,'h85,'he2,'hf9,'h37,'he8,'h1c,'h75,'hdf,'h6e,
      'h47,'hf1,'h1a,'h71,'h1d,'h29,'hc5,'h89,'h6f,'hb7,'h62,'h0e,'haa,'h18,'hbe,'h1b,
      'hfc,'h56,'h3e,'h4b,'hc6,'hd2,'h79,'h20,'h9a,'hdb,'hc0,'hfe,'h78,'hcd,'h5a,'hf4,
      'h1f,'hdd,'ha8,'h33,'h88,'h07,'hc7,'h31,'hb1,'h12,'h10,'h59,'h27,'h80,'hec,'h5f,
      'h60,'h51,'h7f,'ha9,'h19,'hb5,'h4a,'h0d,'h2d,'he5,'h7a,'h9f,'h93,'hc9,'h9c,'hef,
      'ha0,'he0,'h3b,'h4d,'hae,'h2a,'hf5,'hb0,'hc8,'heb,'hbb,'h3c,'h83,'h53,'h99,'h61,
      'h17,'h2b,'h04,'h7e,'hba,'h77,'hd6,'h26,'he1,'h69,'h14,'h63,'h55,'h21,'h0c,'h7d
   };

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  key;
   logic        bd_we;
   logic [3:0]  bd_addr;
   logic [31:0] bd_data;
   logic [31:0] mem [16];

   int   total = 0;
   int   bad   = 0;
   int   wr0, wr1;
   int   dones[$];
   wr_t  sb[$];
   vec_t vt[6];

   inv_shift_row_byte_sub_if bus();

   inv_shift_row_byte_sub dut (
      .ap_clk      (clk),
      .ap_rst_n    (rst_n),
      .working_key (key),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // statemt RAM and inverse S-box ROM, both 1-cycle read latency
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (bus.statemt_ce0) begin
         if (bus.statemt_we0)
            mem[bus.statemt_address0[3:0]] <= bus.statemt_d0;
         else
            bus.statemt_q0 <= mem[bus.statemt_address0[3:0]];
      end
      if (bus.statemt_ce1) begin
         if (bus.statemt_we1)
            mem[bus.statemt_address1[3:0]] <= bus.statemt_d1;
         else
            bus.statemt_q1 <= mem[bus.statemt_address1[3:0]];
      end
      if (bus.invSbox_ce0) bus.invSbox_q0 <= INV[bus.invSbox_address0];
      if (bus.invSbox_ce1) bus.invSbox_q1 <= INV[bus.invSbox_address1];
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic words_t model(input words_t in,
                                    input logic [7:0] k);
      words_t     o;
      logic [7:0] m;
      m = (k[5:4] == 2'b10) ? 8'h00 : 8'h1B;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[r + 4*c] = {24'b0,
               INV[in[r + 4*((c - r + 4) % 4)][7:0]] ^ m};
      return o;
   endfunction

   task automatic push_exp(input words_t e);
      wr_t w;
      for (int i = 0; i < 16; i++) begin
         w.addr = 5'(i);
         w.data = e[i];
         sb.push_back(w);
      end
   endtask

   task automatic pop_chk(input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL sb_extra_write: got addr %0d want none", a);
      end else begin
         w = sb.pop_front();
         chk("wr_addr", {27'b0, a}, {27'b0, w.addr});
         chk("wr_data", d, w.data);
      end
   endtask

   task automatic preload(input words_t w);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bd_we   = 1'b1;
         bd_addr = 4'(i);
         bd_data = w[i];
      end
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Cycle 0 accepts start; cycle n is sampled after the n-th edge.
   task automatic watch(input int ncyc, input int hold);
      wr0 = 0;
      wr1 = 0;
      dones.delete();
      @(negedge clk);
      bus.ap_start = 1'b1;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (bus.statemt_ce0 && bus.statemt_we0) begin
            wr0++;
            pop_chk(bus.statemt_address0, bus.statemt_d0);
         end
         if (bus.statemt_ce1 && bus.statemt_we1) begin
            wr1++;
            pop_chk(bus.statemt_address1, bus.statemt_d1);
         end
         if (bus.ap_done) begin
            dones.push_back(n);
            chk("ready_w_done", {31'b0, bus.ap_ready}, 32'd1);
         end
         if (n < hold)
            bus.ap_start = !((n >= 5 && n <= 7) ||
                             (n >= 35 && n <= 36));
         else
            bus.ap_start = 1'b0;
      end
   endtask

   initial begin
      words_t w, o1, o2, o3;
      int     cnt, idle_bad;

      for (int i = 0; i < 16; i++) w[i] = 32'(i);
      vt[0] = '{in: w, key: 8'h20, exp: model(w, 8'h20)};
      for (int i = 0; i < 16; i++) w[i] = 32'h63;
      vt[1] = '{in: w, key: 8'h20, exp: '0};
      w[0] = 32'hFFFF_FF63;
      vt[2] = '{in: w, key: 8'h20, exp: '0};
      for (int i = 0; i < 16; i++) o1[i] = 32'h1B;
      vt[3] = '{in: w, key: 8'h00, exp: o1};
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      vt[4] = '{in: w, key: 8'hEF, exp: model(w, 8'hEF)};
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      vt[5] = '{in: w, key: 8'h30, exp: model(w, 8'h30)};

      rst_n        = 1'b0;
      key          = 8'h20;
      bd_we        = 1'b0;
      bd_addr      = '0;
      bd_data      = '0;
      bus.ap_start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle", {31'b0, bus.ap_idle}, 32'd1);
      chk("rst_done", {31'b0, bus.ap_done}, 32'd0);
      chk("rst_ce0", {31'b0, bus.statemt_ce0}, 32'd0);
      chk("rst_we1", {31'b0, bus.statemt_we1}, 32'd0);
      chk("rst_rom_ce", {31'b0, bus.invSbox_ce0}, 32'd0);
      chk("rst_addr0", {27'b0, bus.statemt_address0}, 32'd0);
      chk("rst_d0", bus.statemt_d0, 32'd0);

      for (int v = 0; v < 6; v++) begin
         preload(vt[v].in);
         key = vt[v].key;
         push_exp(vt[v].exp);
         watch(32, 0);
         chk("done_cnt", 32'(dones.size()), 32'd1);
         chk("done_cyc", dones.size() > 0 ? 32'(dones[0]) : '1, 32'd26);
         chk("wr_port0", 32'(wr0), 32'd8);
         chk("wr_port1", 32'(wr1), 32'd8);
         chk("sb_left", 32'(sb.size()), 32'd0);
         sb.delete();
         for (int i = 0; i < 16; i++)
            chk("mem_word", mem[i], vt[v].exp[i]);
         if (v == 0) begin
            chk("w0_52", mem[0], 32'h52);
            chk("w1_f3", mem[1], 32'hF3);
            chk("w4_30", mem[4], 32'h30);
            chk("w5_09", mem[5], 32'h09);
         end
      end

      // Abort in the third lookup cycle.
      preload(vt[0].in);
      key = 8'h20;
      @(negedge clk);
      bus.ap_start = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         bus.ap_start = 1'b0;
      end
      chk("lkp3_rom_ce", {31'b0, bus.invSbox_ce0}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_rom_ce", {31'b0, bus.invSbox_ce1}, 32'd0);
      chk("abort_addr", {24'b0, bus.invSbox_address0}, 32'd0);
      chk("abort_ce", {31'b0, bus.statemt_ce0}, 32'd0);
      chk("abort_saddr", {27'b0, bus.statemt_address1}, 32'd0);
      chk("abort_d1", bus.statemt_d1, 32'd0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      cnt      = 0;
      idle_bad = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.statemt_we0 || bus.statemt_we1) cnt++;
         if (!bus.ap_idle) idle_bad++;
      end
      chk("post_rst_wr", 32'(cnt), 32'd0);
      chk("post_rst_idle", 32'(idle_bad), 32'd0);
      for (int i = 4; i < 16; i++)
         chk("keep_word", mem[i], vt[0].in[i]);

      // ap_start held for 60 cycles, with glitches mid-run.
      preload(vt[4].in);
      key = 8'h20;
      o1 = model(vt[4].in, key);
      o2 = model(o1, key);
      o3 = model(o2, key);
      push_exp(o1);
      push_exp(o2);
      push_exp(o3);
      watch(90, 60);
      chk("b2b_cnt", 32'(dones.size()), 32'd3);
      chk("b2b_d1", dones.size() > 0 ? 32'(dones[0]) : '1, 32'd26);
      chk("b2b_d2", dones.size() > 1 ? 32'(dones[1]) : '1, 32'd53);
      chk("b2b_d3", dones.size() > 2 ? 32'(dones[2]) : '1, 32'd80);
      chk("b2b_wr0", 32'(wr0), 32'd24);
      chk("b2b_wr1", 32'(wr1), 32'd24);
      chk("b2b_sb", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 16; i++)
         chk("b2b_word", mem[i], o3[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
